// File: rtl/stepper_homing_seq_pkg.sv
// Shared types and constants for the stepper homing sequencer.
package stepper_pkg;

  typedef struct packed {
    logic [7:0]  speed;
    logic [23:0] pos;
  } ctrl_word_t;

  typedef enum logic [2:0] {
    IDLE,
    SEEK,
    ZERO1,
    BACKOFF,
    ZERO2,
    FAULT
  } home_state_t;

  localparam int unsigned STEP_RESET_CYCLES = 2;

endpackage

// File: rtl/stepper_homing_seq_limit_debounce.sv
// Limit switch conditioning: 2-FF synchronizer followed by a stability debouncer.
module limit_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic limit_n_i,
  output logic pressed_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q, last_q, pressed_q;
  logic [CW-1:0] cnt_q;

  // Counter saturates at CNT_MAX so a long-stable input keeps re-asserting the same level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
    end else begin
      sync1_q <= limit_n_i;
      sync2_q <= sync1_q;
      last_q  <= sync2_q;
      if (sync2_q != last_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        pressed_q <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign pressed_o = pressed_q;

endmodule

// File: rtl/stepper_homing_seq.sv
// Homing/command sequencer driving one stepper channel's control word, homing mode and reset.
module stepper_homing_seq
  import stepper_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50_000,
  parameter logic [23:0] BACKOFF_STEPS   = 24'd200,
  parameter logic [7:0]  BACKOFF_SPEED   = 8'd2,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd250_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_home,
  input  logic [7:0]  cmd_speed,
  input  logic [23:0] cmd_pos,
  input  logic        limit_n,
  input  logic        step_in,
  output logic [31:0] control,
  output logic        homing_enable,
  output logic        stepper_reset,
  output logic        busy,
  output logic        homed,
  output logic        fault
);

  localparam logic [1:0] ZLAST = 2'(STEP_RESET_CYCLES - 1);

  home_state_t state_q, state_d;
  ctrl_word_t  ctrl_q, ctrl_d;
  logic        hen_q, hen_d, srst_q, srst_d, homed_q, homed_d, fault_q, fault_d;
  logic [31:0] tmo_q, tmo_d;
  logic [23:0] steps_q, steps_d;
  logic [1:0]  zcnt_q, zcnt_d;
  logic        step_prev_q, step_edge, lim_pressed;

  limit_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lim (
    .clk       (clk),
    .reset_n   (reset_n),
    .limit_n_i (limit_n),
    .pressed_o (lim_pressed)
  );

  assign step_edge = step_in & ~step_prev_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ctrl_q      <= '0;
      hen_q       <= 1'b0;
      srst_q      <= 1'b1;
      homed_q     <= 1'b0;
      fault_q     <= 1'b0;
      tmo_q       <= '0;
      steps_q     <= '0;
      zcnt_q      <= '0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      hen_q       <= hen_d;
      srst_q      <= srst_d;
      homed_q     <= homed_d;
      fault_q     <= fault_d;
      tmo_q       <= tmo_d;
      steps_q     <= steps_d;
      zcnt_q      <= zcnt_d;
      step_prev_q <= step_in;
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    hen_d   = hen_q;
    srst_d  = srst_q;
    homed_d = homed_q;
    fault_d = fault_q;
    tmo_d   = tmo_q;
    steps_d = steps_q;
    zcnt_d  = zcnt_q;
    unique case (state_q)
      IDLE: begin
        srst_d = 1'b0;
        hen_d  = 1'b0;
        if (cmd_valid) begin
          if (cmd_home) begin
            state_d = SEEK;
            fault_d = 1'b0;
            homed_d = 1'b0;
            hen_d   = 1'b1;
            tmo_d   = '0;
          end else if (homed_q) begin
            ctrl_d = '{speed: cmd_speed, pos: cmd_pos};
          end else begin
            fault_d = 1'b1;
          end
        end
      end
      SEEK: begin
        hen_d = 1'b1;
        // Switch is checked before the timeout so a coincident press still homes.
        if (lim_pressed) begin
          state_d = ZERO1;
          hen_d   = 1'b0;
          srst_d  = 1'b1;
          ctrl_d  = '{speed: BACKOFF_SPEED, pos: '0};
          steps_d = '0;
          zcnt_d  = '0;
        end else if (tmo_q == TIMEOUT_CYCLES - 32'd1) begin
          state_d = FAULT;
          fault_d = 1'b1;
          hen_d   = 1'b0;
          srst_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      ZERO1: begin
        steps_d = '0;
        if (zcnt_q == ZLAST) begin
          state_d = BACKOFF;
          srst_d  = 1'b0;
          ctrl_d  = '{speed: BACKOFF_SPEED, pos: BACKOFF_STEPS};
        end else begin
          zcnt_d = zcnt_q + 2'd1;
        end
      end
      BACKOFF: begin
        if (steps_q == BACKOFF_STEPS) begin
          if (lim_pressed) begin
            state_d = FAULT;
            fault_d = 1'b1;
            srst_d  = 1'b1;
          end else begin
            state_d = ZERO2;
            srst_d  = 1'b1;
            ctrl_d  = '{speed: BACKOFF_SPEED, pos: '0};
            zcnt_d  = '0;
          end
        end else if (step_edge) begin
          steps_d = steps_q + 24'd1;
        end
      end
      ZERO2: begin
        if (zcnt_q == ZLAST) begin
          state_d = IDLE;
          srst_d  = 1'b0;
          homed_d = 1'b1;
        end else begin
          zcnt_d = zcnt_q + 2'd1;
        end
      end
      FAULT: begin
        fault_d = 1'b1;
        hen_d   = 1'b0;
        srst_d  = 1'b1;
        if (cmd_valid && cmd_home) begin
          state_d = SEEK;
          fault_d = 1'b0;
          srst_d  = 1'b0;
          hen_d   = 1'b1;
          homed_d = 1'b0;
          tmo_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready     = (state_q == IDLE) || (state_q == FAULT);
  assign busy          = ~cmd_ready;
  assign control       = ctrl_q;
  assign homing_enable = hen_q;
  assign stepper_reset = srst_q;
  assign homed         = homed_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_stepper_homing_seq.sv
// Bench for stepper_homing_seq: directed scenarios plus random traffic against a behavioural model.
module tb_stepper_homing_seq;

  localparam int unsigned DEB  = 4;
  localparam int unsigned BST  = 3;
  localparam int unsigned TMO  = 1000;
  localparam int unsigned HLEN = DEB + 3;

  localparam int P_IDLE = 0, P_SEEK = 1, P_Z1 = 2, P_BACK = 3, P_Z2 = 4, P_FAULT = 5;

  logic        clk = 1'b0;
  logic        reset_n, cmd_valid, cmd_ready, cmd_home, limit_n, step_in;
  logic [7:0]  cmd_speed;
  logic [23:0] cmd_pos;
  logic [31:0] control;
  logic        homing_enable, stepper_reset, busy, homed, fault;

  int n_vec = 0;
  int n_err = 0;

  stepper_homing_seq #(
    .DEBOUNCE_CYCLES(DEB),
    .BACKOFF_STEPS  (24'(BST)),
    .BACKOFF_SPEED  (8'd2),
    .TIMEOUT_CYCLES (32'(TMO))
  ) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_home(cmd_home), .cmd_speed(cmd_speed), .cmd_pos(cmd_pos),
    .limit_n(limit_n), .step_in(step_in), .control(control),
    .homing_enable(homing_enable), .stepper_reset(stepper_reset),
    .busy(busy), .homed(homed), .fault(fault)
  );

  always #5 clk = ~clk;

  // inputs as seen by the DUT at each rising edge
  logic        s_rst_n, s_valid, s_home, s_lim, s_step;
  logic [7:0]  s_spd;
  logic [23:0] s_pos;
  always @(posedge clk) begin
    s_rst_n <= reset_n; s_valid <= cmd_valid; s_home <= cmd_home;
    s_spd <= cmd_speed; s_pos <= cmd_pos; s_lim <= limit_n; s_step <= step_in;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // behavioural model
  int          m_phase, m_age, m_steps;
  logic [31:0] m_ctrl;
  logic        m_hen, m_srst, m_homed, m_fault, m_press, m_prev;
  logic        hist [HLEN];

  task automatic model_step();
    logic p, edge_s, stable, ready;
    if (!s_rst_n) begin
      m_phase = P_IDLE; m_ctrl = '0; m_hen = 0; m_srst = 1; m_homed = 0; m_fault = 0;
      m_press = 0; m_prev = 0; m_age = 0; m_steps = 0;
      for (int i = 0; i < HLEN; i++) hist[i] = 1'b1;
      return;
    end
    edge_s = s_step && !m_prev;
    m_prev = s_step;
    p = m_press;
    for (int i = HLEN - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s_lim;
    // pressed follows the switch once it has read the same value DEB+1 times, 2 samples back
    stable = 1'b1;
    for (int i = 3; i < HLEN; i++) if (hist[i] != hist[2]) stable = 1'b0;
    if (stable) m_press = ~hist[2];
    ready = (m_phase == P_IDLE) || (m_phase == P_FAULT);
    case (m_phase)
      P_IDLE: begin
        m_srst = 0; m_hen = 0;
        if (s_valid && ready) begin
          if (s_home) begin m_phase = P_SEEK; m_fault = 0; m_homed = 0; m_hen = 1; m_age = 0; end
          else if (m_homed) m_ctrl = {s_spd, s_pos};
          else m_fault = 1;
        end
      end
      P_SEEK: begin
        if (p) begin m_phase = P_Z1; m_hen = 0; m_srst = 1; m_ctrl = 32'h0200_0000; m_age = 0; end
        else if (m_age == TMO - 1) begin m_phase = P_FAULT; m_fault = 1; m_hen = 0; m_srst = 1; end
        else m_age++;
      end
      P_Z1: begin
        m_age++;
        if (m_age == 2) begin m_phase = P_BACK; m_srst = 0; m_ctrl = 32'h0200_0000 | BST; m_steps = 0; end
      end
      P_BACK: begin
        if (m_steps == BST) begin
          if (p) begin m_phase = P_FAULT; m_fault = 1; m_srst = 1; end
          else begin m_phase = P_Z2; m_srst = 1; m_ctrl = 32'h0200_0000; m_age = 0; end
        end else if (edge_s) m_steps++;
      end
      P_Z2: begin
        m_age++;
        if (m_age == 2) begin m_phase = P_IDLE; m_srst = 0; m_homed = 1; end
      end
      default: begin
        if (s_valid && s_home) begin
          m_phase = P_SEEK; m_fault = 0; m_srst = 0; m_hen = 1; m_homed = 0; m_age = 0;
        end
      end
    endcase
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_step();
      chk("control", control, m_ctrl);
      chk("homing_enable", {31'd0, homing_enable}, {31'd0, m_hen});
      chk("stepper_reset", {31'd0, stepper_reset}, {31'd0, m_srst});
      chk("homed", {31'd0, homed}, {31'd0, m_homed});
      chk("fault", {31'd0, fault}, {31'd0, m_fault});
      chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, (m_phase == P_IDLE || m_phase == P_FAULT)});
      chk("busy", {31'd0, busy}, {31'd0, !(m_phase == P_IDLE || m_phase == P_FAULT)});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic h, input logic [7:0] s, input logic [23:0] p);
    int n = 0;
    cmd_valid = 1; cmd_home = h; cmd_speed = s; cmd_pos = p;
    while (!cmd_ready && n < 5000) begin cyc(1); n++; end
    if (!cmd_ready) chk("handshake_timeout", 32'd0, 32'd1);
    cyc(1);
    cmd_valid = 0;
  endtask

  task automatic pulse();
    step_in = 1; cyc(1); step_in = 0; cyc(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hold;
    reset_n = 0; cmd_valid = 0; cmd_home = 0; cmd_speed = 0; cmd_pos = 0;
    limit_n = 1; step_in = 0;
    cyc(2);
    chk("rst_control", control, 32'h0);
    chk("rst_srst", {31'd0, stepper_reset}, 32'd1);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    reset_n = 1;
    cyc(1);
    chk("srst_release", {31'd0, stepper_reset}, 32'd0);

    // move before homing is dropped with a fault
    send(0, 8'd5, 24'd100);
    chk("t1_control", control, 32'h0);
    chk("t1_fault", {31'd0, fault}, 32'd1);
    chk("t1_homed", {31'd0, homed}, 32'd0);

    // successful homing
    send(1, 8'd0, 24'd0);
    cyc(50);
    limit_n = 0;
    cyc(7);
    chk("t2_hen_pre", {31'd0, homing_enable}, 32'd1);
    cyc(1);
    chk("t2_hen_fall", {31'd0, homing_enable}, 32'd0);
    chk("t2_ctrl_z1", control, 32'h0200_0000);
    cyc(1);
    chk("t2_srst_2nd", {31'd0, stepper_reset}, 32'd1);
    cyc(1);
    chk("t2_srst_off", {31'd0, stepper_reset}, 32'd0);
    chk("t2_ctrl_back", control, 32'h0200_0003);
    limit_n = 1;
    cyc(8);
    repeat (3) pulse();
    n = 0;
    while (busy && n < 20) begin cyc(1); n++; end
    chk("t3_done", {31'd0, busy}, 32'd0);
    chk("t3_homed", {31'd0, homed}, 32'd1);
    send(0, 8'd10, 24'h000400);
    chk("t3_move", control, 32'h0A00_0400);

    // seek timeout, then recovery
    send(1, 8'd0, 24'd0);
    n = 0;
    while (!fault && n < 1100) begin cyc(1); n++; end
    chk("t4_tmo_cycles", n, 32'd1000);
    chk("t4_hen", {31'd0, homing_enable}, 32'd0);
    chk("t4_srst", {31'd0, stepper_reset}, 32'd1);
    send(1, 8'd0, 24'd0);
    chk("t4_fault_clr", {31'd0, fault}, 32'd0);
    chk("t4_seek", {31'd0, homing_enable}, 32'd1);

    // bouncing switch must not trigger early
    limit_n = 0; cyc(1); limit_n = 1; cyc(1); limit_n = 0; cyc(1); limit_n = 1; cyc(1);
    limit_n = 0;
    n = 0;
    while (homing_enable && n < 50) begin cyc(1); n++; end
    chk("t5_debounce", n, 32'd8);

    // reset in the middle of back-off
    cyc(2);
    limit_n = 1;
    pulse();
    reset_n = 0;
    cyc(1);
    chk("t6_control", control, 32'h0);
    chk("t6_srst", {31'd0, stepper_reset}, 32'd1);
    chk("t6_ready", {31'd0, cmd_ready}, 32'd1);
    reset_n = 1;

    // random traffic
    hold = 10;
    for (int i = 0; i < 6000; i++) begin
      cmd_valid = ($urandom_range(0, 7) == 0);
      cmd_home  = ($urandom_range(0, 2) == 0);
      cmd_speed = 8'($urandom);
      cmd_pos   = 24'($urandom);
      step_in   = 1'($urandom);
      if (hold == 0) begin limit_n = ~limit_n; hold = $urandom_range(1, 60); end
      else hold--;
      reset_n = ($urandom_range(0, 999) != 0);
      cyc(1);
    end
    cmd_valid = 0; reset_n = 1;
    cyc(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
